// File: rtl/hazard_unit_scoreboard.sv
// Hazard unit for the RV32I D/E/M/W pipeline. It handles E-stage operand
// forwarding, load-use stalls and branch/jump flushes. It also holds a
// one-entry scoreboard for the long-latency mul/div unit, which has a
// watchdog and a saturating stall-cycle counter.
module hazard_unit_scoreboard #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT     = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  Rs1D,
    input  logic [REG_ADDR_W-1:0]  Rs2D,
    input  logic [REG_ADDR_W-1:0]  Rs1E,
    input  logic [REG_ADDR_W-1:0]  Rs2E,
    input  logic [REG_ADDR_W-1:0]  RdE,
    input  logic [REG_ADDR_W-1:0]  RdM,
    input  logic [REG_ADDR_W-1:0]  RdW,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic [1:0]             ResultSrcE,
    input  logic [1:0]             PCSrcE,
    input  logic [DATA_WIDTH-1:0]  RD1E,
    input  logic [DATA_WIDTH-1:0]  RD2E,
    input  logic [DATA_WIDTH-1:0]  ALUResultM,
    input  logic [DATA_WIDTH-1:0]  ResultW,
    input  logic                   LongOpD,
    input  logic                   LongStartE,
    input  logic [REG_ADDR_W-1:0]  LongRdE,
    input  logic                   LongDoneW,
    output logic [DATA_WIDTH-1:0]  SrcAE,
    output logic [DATA_WIDTH-1:0]  WriteDataE,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   FEN,
    output logic                   DEN,
    output logic                   RSTD,
    output logic                   RSTE,
    output logic                   LongBusy,
    output logic                   LongTimeout,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic                  busy;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [WD_W-1:0]       wd_cnt;
    logic                  lw, lh, stall, redirect, start, wd_fire;

    // Forwarding selects. A match in M has priority over a match in W, and x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != '0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs1E) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != '0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    // Operand muxes. The unused code 11 falls back to the register-file value.
    always_comb begin
        case (ForwardAE)
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUResultM;
            default: WriteDataE = RD2E;
        endcase
    end

    // Stall/flush decision. A redirect squashes D and E and wins over any stall.
    always_comb begin
        lw       = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        lh       = busy && (((pend_rd != '0) && ((Rs1D == pend_rd) || (Rs2D == pend_rd))) || LongOpD);
        redirect = (PCSrcE != 2'b00);
        stall    = (lw || lh) && !redirect;
        FEN      = !stall;
        DEN      = !stall;
        RSTD     = redirect;
        RSTE     = stall || redirect;
        start    = LongStartE && (LongRdE != '0);
        wd_fire  = busy && (wd_cnt == WD_LAST);
    end

    // Scoreboard state. A new start beats a completion or a timeout in the same cycle, so one op hands off to the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            pend_rd     <= '0;
            wd_cnt      <= '0;
            LongTimeout <= 1'b0;
        end else begin
            LongTimeout <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                pend_rd <= LongRdE;
                wd_cnt  <= '0;
            end else if (wd_fire) begin
                busy        <= 1'b0;
                wd_cnt      <= '0;
                LongTimeout <= !LongDoneW;
            end else if (busy && LongDoneW) begin
                busy   <= 1'b0;
                wd_cnt <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Stall-cycle performance counter. It saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            StallCount <= '0;
        else if (stall && StallCount != '1) StallCount <= StallCount + 1'b1;
    end

    assign LongBusy = busy;

endmodule

// File: tb/tb_hazard_unit_scoreboard.sv
// Randomised and directed bench for hazard_unit_scoreboard. A reference
// model built from the rules predicts every output. The model tracks the
// pending op by its absolute deadline cycle, not by a counter.
module tb_hazard_unit_scoreboard;

    localparam int DW = 32, AW = 5, TO = 64, SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 0, rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, LongRdE;
    logic RegWriteM, RegWriteW, LongOpD, LongStartE, LongDoneW;
    logic [1:0] ResultSrcE, PCSrcE;
    logic [DW-1:0] RD1E, RD2E, ALUResultM, ResultW;
    logic [DW-1:0] SrcAE, WriteDataE;
    logic [1:0] ForwardAE, ForwardBE;
    logic FEN, DEN, RSTD, RSTE, LongBusy, LongTimeout;
    logic [SW-1:0] StallCount;

    hazard_unit_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD1E(RD1E), .RD2E(RD2E),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .LongOpD(LongOpD),
        .LongStartE(LongStartE), .LongRdE(LongRdE), .LongDoneW(LongDoneW),
        .SrcAE(SrcAE), .WriteDataE(WriteDataE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .FEN(FEN), .DEN(DEN), .RSTD(RSTD), .RSTE(RSTE), .LongBusy(LongBusy),
        .LongTimeout(LongTimeout), .StallCount(StallCount));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, to_seen = 0;
    // Reference model state.
    bit m_busy, m_to;
    int m_pend, m_deadline, m_sc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int fwd(input int rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit lw, lh;
        lw = ResultSrcE == 1 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        lh = m_busy && ((m_pend != 0 && (Rs1D == m_pend || Rs2D == m_pend)) || LongOpD);
        return (lw || lh) && PCSrcE == 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_to = 0; m_pend = 0; m_sc = 0; m_deadline = 0;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0; LongRdE = 0;
        RegWriteM = 0; RegWriteW = 0; LongOpD = 0; LongStartE = 0; LongDoneW = 0;
        ResultSrcE = 0; PCSrcE = 0; RD1E = 32'h1111; RD2E = 32'h2222;
        ALUResultM = 32'hAAAA; ResultW = 32'hBBBB;
    endtask

    // The inputs are already driven at the negedge. Check all outputs, take one clock edge and advance the model.
    task automatic step();
        int fa, fb;
        bit st, redir, to_next;
        logic [DW-1:0] ea, eb;
        #1;
        fa = fwd(Rs1E); fb = fwd(Rs2E);
        ea = (fa == 2) ? ALUResultM : (fa == 1) ? ResultW : RD1E;
        eb = (fb == 2) ? ALUResultM : (fb == 1) ? ResultW : RD2E;
        st = exp_stall(); redir = PCSrcE != 0;
        chk("fwdA", ForwardAE, fa[1:0]);
        chk("fwdB", ForwardBE, fb[1:0]);
        chk("srcA", SrcAE, ea);
        chk("wdata", WriteDataE, eb);
        chk("fen_den", {FEN, DEN}, {!st, !st});
        chk("rstd_rste", {RSTD, RSTE}, {redir, st || redir});
        chk("busy", LongBusy, m_busy);
        chk("timeout", LongTimeout, m_to);
        chk("stallcnt", StallCount, m_sc[SW-1:0]);
        if (LongTimeout) to_seen++;
        @(posedge clk);
        cyc++;
        to_next = m_busy && cyc == m_deadline && !LongDoneW;
        if (LongStartE && LongRdE != 0) begin
            m_busy = 1; m_pend = LongRdE; m_deadline = cyc + TO; to_next = 0;
        end else if (m_busy && (cyc == m_deadline || LongDoneW)) begin
            m_busy = 0;
        end
        m_to = to_next;
        if (st && m_sc < SMAX) m_sc++;
        @(negedge clk);
    endtask

    initial begin
        idle(); rst = 1; model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_busy", LongBusy, 0);
        chk("rst_cnt", StallCount, 0);
        chk("rst_to", LongTimeout, 0);
        rst = 0;

        // Forwarding: M has priority over W, and x0 never forwards.
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        #1 chk("fwd_prio", ForwardAE, 2'b10); chk("fwd_prio_data", SrcAE, 32'hAAAA);
        step();
        Rs1E = 0; #1 chk("fwd_x0", ForwardAE, 2'b00);
        step();

        // Load-use stall, then the same stall with a redirect.
        idle(); ResultSrcE = 1; RdE = 7; Rs2D = 7;
        #1 chk("lu_stall", {FEN, DEN, RSTE}, 3'b001);
        step(); chk("lu_cnt", StallCount, 1);
        PCSrcE = 1;
        #1 chk("lu_redir", {FEN, DEN, RSTD, RSTE}, 4'b1111);
        step();

        // Long-op dependency: the stall holds through the done cycle and is gone on the next cycle.
        idle(); LongStartE = 1; LongRdE = 9; step();
        LongStartE = 0; Rs1D = 9;
        repeat (9) step();
        LongDoneW = 1;
        #1 chk("dep_done_stall", FEN, 0);
        step();
        LongDoneW = 0;
        #1 chk("dep_release", {FEN, LongBusy}, 2'b10);
        step();

        // Structural hazard, then a completion and a new start in the same cycle.
        idle(); LongStartE = 1; LongRdE = 4; step();
        LongStartE = 0; LongOpD = 1; Rs1D = 1; Rs2D = 2;
        #1 chk("struct_stall", FEN, 0);
        step();
        LongOpD = 0; LongDoneW = 1; LongStartE = 1; LongRdE = 12; step();
        idle(); Rs2D = 12;
        #1 chk("handoff", {LongBusy, FEN}, 2'b10);
        step();

        // Watchdog: expect a single timeout pulse, after which the stall on x3 clears.
        idle(); LongDoneW = 1; repeat (TO + 2) step();
        idle(); LongStartE = 1; LongRdE = 3; step();
        LongStartE = 0; Rs1D = 3; to_seen = 0;
        repeat (TO + 4) step();
        chk("wd_pulses", to_seen, 1);
        chk("wd_release", {LongBusy, FEN}, 2'b01);

        // Asynchronous reset while an op is pending: LongBusy drops before any clock edge.
        idle(); LongStartE = 1; LongRdE = 6; step();
        idle(); step();
        #2 rst = 1; #1;
        chk("async_rst", LongBusy, 0);
        chk("async_rst_to", LongTimeout, 0);
        model_reset();
        @(negedge clk); rst = 0;

        // Saturation: hold a load-use stall for 20 cycles.
        idle(); ResultSrcE = 1; RdE = 7; Rs1D = 7;
        repeat (20) step();
        chk("sat", StallCount, 4'hF);
        rst = 1; #1 model_reset(); @(negedge clk); rst = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            Rs1D = $urandom_range(0, 7); Rs2D = $urandom_range(0, 7);
            Rs1E = $urandom_range(0, 7); Rs2E = $urandom_range(0, 7);
            RdE = $urandom_range(0, 7); RdM = $urandom_range(0, 7); RdW = $urandom_range(0, 7);
            RegWriteM = $urandom; RegWriteW = $urandom; ResultSrcE = $urandom;
            PCSrcE = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            RD1E = $urandom; RD2E = $urandom; ALUResultM = $urandom; ResultW = $urandom;
            LongOpD = ($urandom_range(0, 3) == 0);
            LongStartE = ($urandom_range(0, 29) == 0); LongRdE = $urandom_range(0, 7);
            LongDoneW = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_scoreboard.md
Name: hazard_unit_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit, sitting beside the D/E/M/W pipeline registers of the RV32I core.
- Provides:
  - E-stage operand forwarding with generic data and register-index widths.
  - Load-use stall.
  - Control-hazard flush.
  - A sequential scoreboard for one outstanding long-latency operation (mul/div unit): it tracks the pending destination register, stalls dependent or structurally conflicting instructions in D, and runs a watchdog plus a stall performance counter.

Parameters:
- DATA_WIDTH, 32, width of operand/result buses
- REG_ADDR_W, 5, register index width
- TIMEOUT, 64, busy cycles before the watchdog force-clears the scoreboard (must be ≥2)
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  REG_ADDR_W  D-stage source registers
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  E-stage sources/destination
- RdM, RdW  in  REG_ADDR_W  M/W destinations
- RegWriteM, RegWriteW  in  1  destination actually written
- ResultSrcE  in  2  2'b01 = load in E
- PCSrcE  in  2  nonzero = taken branch/jump redirect in E
- RD1E, RD2E, ALUResultM, ResultW  in  DATA_WIDTH  operand/forward sources
- LongOpD  in  1  D instruction targets the long unit
- LongStartE  in  1  long op issuing from E this cycle
- LongRdE  in  REG_ADDR_W  destination of the issuing long op
- LongDoneW  in  1  long unit writes its result this cycle (single-cycle pulse)
- SrcAE, WriteDataE  out  DATA_WIDTH  forwarded operands
- ForwardAE, ForwardBE  out  2  mux selects: 00 RD, 01 ResultW, 10 ALUResultM
- FEN, DEN  out  1  fetch/decode register enables
- RSTD, RSTE  out  1  D/E pipeline register flushes
- LongBusy  out  1  scoreboard occupied
- LongTimeout  out  1  one-cycle watchdog pulse
- StallCount  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Busy=0, PendRd=0, WdCnt=0, StallCount=0, LongTimeout=0.
  - Combinational outputs then follow the rules below using the cleared state.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
  - SrcAE/WriteDataE are the selected inputs; select 11 gives RD.
- Load-use hazard: lw = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Long-op hazard: lh = Busy && ((PendRd!=0 && (Rs1D==PendRd || Rs2D==PendRd)) || LongOpD).
- stall = (lw || lh) && PCSrcE==0.
  - Stall: FEN=DEN=0, RSTE=1 (bubble into E).
- Redirect (PCSrcE!=0): RSTD=1, RSTE=1, FEN=DEN=1. Redirect overrides stall.
- Otherwise FEN=DEN=1, RSTD=RSTE=0.
- Scoreboard, evaluated at the clk edge with this priority:
  - LongTimeout is 0 by default each cycle.
  - Watchdog: if Busy && WdCnt==TIMEOUT-1, then Busy←0, LongTimeout←1 (one cycle).
    - A LongDoneW in that same cycle clears Busy without raising LongTimeout.
  - Otherwise, LongDoneW && Busy → Busy←0.
  - LongDoneW while not Busy is ignored.
  - LongStartE && LongRdE!=0 → Busy←1, PendRd←LongRdE, WdCnt←0.
    - Start overrides a simultaneous done or timeout, which is a back-to-back handoff.
  - LongStartE with LongRdE==0 does not set Busy.
- WdCnt:
  - Increments each Busy cycle; held at 0 when not Busy.
  - Reset to 0 on start.
- The dependency stall holds through the LongDoneW cycle and releases the following cycle. The register file then holds the result.
- StallCount increments each cycle stall==1 and saturates at all-ones.
- Reset asserted mid-operation aborts the pending op: Busy=0, no LongTimeout.

Test Plan:
- Forwarding priority: RdM=RdW=Rs1E=5, both RegWrite=1, ALUResultM=0xAAAA, ResultW=0xBBBB → ForwardAE=10, SrcAE=0xAAAA. Rs1E=0 with the same inputs → ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → FEN=DEN=0, RSTE=1, StallCount +1. Add PCSrcE=01 → RSTD=RSTE=1, FEN=DEN=1.
- Long dependency: LongStartE, LongRdE=9; next cycles Rs1D=9 → stall asserted. Pulse LongDoneW at cycle 10 → stall remains that cycle, released at cycle 11, Busy=0.
- Structural: Busy=1 and LongOpD=1 with unrelated sources → stall. Back-to-back LongDoneW with LongStartE (Rd=12) → Busy stays 1, PendRd=12, WdCnt=0.
- Watchdog: start with Rd=3, no done → after TIMEOUT=64 busy cycles LongTimeout pulses exactly once, Busy=0, and the stall on Rs1D=3 drops.
- Async reset mid-op plus saturation: assert rst while Busy → Busy=0 without a clk edge. With STALL_CNT_W=4, hold stall 20 cycles → StallCount=15.
